uart_rx_frame_counter: RTL
==========================

// Module: uart_rx_frame_counter
// PURPOSE
//  Oversampling edge/bit counter for the UART RX datapath, successor to the fixed-frame edge/bit counter.
//  Counts prescale edges per bit and bits per frame, with a runtime frame length and a latched prescale.
//  Decodes mid-bit sample strobes, end-of-bit ticks and a frame-done pulse for the RX FSM and sampler.
//  Sits between the RX FSM (drives Enable) and data_sampling/deserializer (consume ticks).
// PARAMETERS
//  PRESCALE_BITS  6  width of prescale and edge_cnt (oversampling up to 63)
//  TX_BITS        4  width of bit_cnt and frame_bits (frames up to 15 bits)
//  MIN_PRESCALE   4  smallest legal prescale; anything lower raises cfg_err
// PORTS
//  CLK         in   1              clock
//  RST         in   1              async reset, active-low
//  Enable      in   1              run request from RX FSM; low = clear counters
//  prescale    in   PRESCALE_BITS  oversampling ratio, sampled at frame start only
//  frame_bits  in   TX_BITS        total bits in frame (start+data+parity+stop), sampled at frame start
//  edge_cnt    out  PRESCALE_BITS  edge index within current bit, 0..pre_q-1
//  bit_cnt     out  TX_BITS        bit index within frame, 0..frm_q-1
//  bit_tick    out  1              last edge of current bit
//  sample_tick out  3              [1]=mid-bit strobe; [0]/[2]=mid-1/mid+1 (macro only)
//  frame_done  out  1              one-cycle pulse on last edge of last bit
//  busy        out  1              state==RUN
//  cfg_err     out  1              sticky: frame start attempted with illegal config
// BEHAVIOUR
//  - Reset: every register and output 0, state IDLE, cfg_err cleared.
//  - States: IDLE, RUN, HOLD. All outputs are decoded from registered state/counters (no input-to-output path).
//  - IDLE: Enable=1 -> latch pre_q<=prescale, frm_q<=frame_bits.
//    If prescale<MIN_PRESCALE or frame_bits<2: set cfg_err and stay IDLE. Otherwise -> RUN with counters at 0.
//  - RUN, Enable=1: edge_cnt increments each cycle.
//    At edge_cnt==pre_q-1: edge_cnt<=0, bit_cnt<=bit_cnt+1, bit_tick=1.
//  - RUN, last edge of bit frm_q-1: frame_done=1 and bit_tick=1 together. Counters <=0, -> HOLD.
//    bit_cnt never reaches frm_q.
//  - HOLD: counters stay 0 and ticks stay low until Enable=0, then -> IDLE (no auto-restart of a second frame).
//  - Enable=0 in any state: next edge clears edge_cnt and bit_cnt, -> IDLE. Mid-frame abort produces no frame_done.
//  - Mid-bit point: mid=pre_q>>1. sample_tick[1]=RUN && edge_cnt==mid.
//    Odd prescale rounds down (prescale 5 -> edge 2).
//  - prescale/frame_bits changes during RUN/HOLD are ignored until the next IDLE->RUN.
//  - cfg_err clears only on a legal IDLE->RUN start.
//  - All counter arithmetic is modulo width; legal configs never wrap.
//  - Latency: first edge_cnt=0 cycle is the cycle after Enable is seen high in IDLE.
//    A frame of N bits at prescale P spans N*P cycles in RUN.
// CONFIGURATION
//  - UART_RX_TRIPLE_SAMPLE_EN defined:
//    sample_tick[0]=RUN && edge_cnt==mid-1; sample_tick[2]=RUN && edge_cnt==mid+1.
//    Used for 2-of-3 majority voting; MIN_PRESCALE guarantees mid-1>=1 and mid+1<pre_q.
//  - Not defined: sample_tick[0] and sample_tick[2] are tied 0; sample_tick[1] is unchanged.
// STRUCTURE
//  - Package uart_rx_pkg: state enum (IDLE/RUN/HOLD), MIN_PRESCALE default, sample-index localparams.
//  - Single flat module. No sub-module: counter and decode share the latched pre_q/mid registers.
// TESTING
//  1. prescale=8, frame_bits=10, Enable held high -> 80 RUN cycles, bit_tick on edge 7 of each bit,
//     sample_tick[1] on edge 4, frame_done once at bit 9 edge 7, then HOLD.
//  2. prescale=5, frame_bits=11 -> mid-bit strobe on edge 2. With the macro, strobes on edges 1/2/3.
//     Without the macro, only sample_tick[1] ever toggles.
//  3. Enable dropped at bit 3 edge 5 -> next cycle edge_cnt=0, bit_cnt=0, IDLE, no frame_done.
//     Re-enable starts a clean frame.
//  4. prescale changed 8->16 at bit 2 -> current frame keeps 8 edges/bit. Next frame uses 16.
//  5. prescale=3 or frame_bits=1 with Enable high -> cfg_err=1, busy=0, counters stay 0.
//     A later legal start clears cfg_err.
//  6. RST asserted mid-frame (async, off-edge) -> all outputs 0 immediately.
//     After release with Enable high -> fresh frame from bit 0.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART RX edge/bit counter.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } rx_state_t;

  localparam int MIN_PRESCALE_DEFAULT = 4;

  // Bit positions within sample_tick.
  localparam int SAMPLE_EARLY = 0;
  localparam int SAMPLE_MID   = 1;
  localparam int SAMPLE_LATE  = 2;

endpackage

// File: rtl/uart_rx_frame_counter.sv
// Oversampling edge/bit counter for UART RX with latched prescale and runtime frame length.
// Define UART_RX_TRIPLE_SAMPLE_EN to add mid-1/mid+1 strobes for majority voting.
module uart_rx_frame_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_BITS = 6,
  parameter int TX_BITS       = 4,
  parameter int MIN_PRESCALE  = MIN_PRESCALE_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Enable,
  input  logic [PRESCALE_BITS-1:0] prescale,
  input  logic [TX_BITS-1:0]       frame_bits,
  output logic [PRESCALE_BITS-1:0] edge_cnt,
  output logic [TX_BITS-1:0]       bit_cnt,
  output logic                     bit_tick,
  output logic [2:0]               sample_tick,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     cfg_err,
  output rx_state_t                state_dbg
);

  localparam logic [PRESCALE_BITS-1:0] ONE_E   = PRESCALE_BITS'(1);
  localparam logic [TX_BITS-1:0]       ONE_B   = TX_BITS'(1);
  localparam logic [PRESCALE_BITS-1:0] MIN_PRE = PRESCALE_BITS'(MIN_PRESCALE);
  localparam logic [TX_BITS-1:0]       MIN_FRM = TX_BITS'(2);

  rx_state_t                state, state_n;
  logic [PRESCALE_BITS-1:0] pre_q, pre_n;
  logic [PRESCALE_BITS-1:0] mid_q, mid_n;
  logic [TX_BITS-1:0]       frm_q, frm_n;
  logic [PRESCALE_BITS-1:0] edge_n;
  logic [TX_BITS-1:0]       bit_n;
  logic                     err_n;
  logic                     run;
  logic                     last_edge;
  logic                     last_bit;
  logic                     cfg_bad;

  assign run       = (state == RUN);
  assign last_edge = (edge_cnt == pre_q - ONE_E);
  assign last_bit  = (bit_cnt == frm_q - ONE_B);
  assign cfg_bad   = (prescale < MIN_PRE) || (frame_bits < MIN_FRM);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      pre_q    <= '0;
      mid_q    <= '0;
      frm_q    <= '0;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_n;
      pre_q    <= pre_n;
      mid_q    <= mid_n;
      frm_q    <= frm_n;
      edge_cnt <= edge_n;
      bit_cnt  <= bit_n;
      cfg_err  <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    pre_n   = pre_q;
    mid_n   = mid_q;
    frm_n   = frm_q;
    edge_n  = edge_cnt;
    bit_n   = bit_cnt;
    err_n   = cfg_err;
    case (state)
      IDLE: begin
        edge_n = '0;
        bit_n  = '0;
        if (Enable) begin
          // Config is captured on every attempt; only a legal one starts a frame.
          pre_n = prescale;
          mid_n = prescale >> 1;
          frm_n = frame_bits;
          if (cfg_bad) begin
            err_n = 1'b1;
          end else begin
            err_n   = 1'b0;
            state_n = RUN;
          end
        end
      end
      RUN: begin
        if (!Enable) begin
          edge_n  = '0;
          bit_n   = '0;
          state_n = IDLE;
        end else if (last_edge) begin
          edge_n = '0;
          if (last_bit) begin
            bit_n   = '0;
            state_n = HOLD;
          end else begin
            bit_n = bit_cnt + ONE_B;
          end
        end else begin
          edge_n = edge_cnt + ONE_E;
        end
      end
      HOLD: begin
        edge_n = '0;
        bit_n  = '0;
        if (!Enable) state_n = IDLE;
      end
      default: begin
        edge_n  = '0;
        bit_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign bit_tick   = run && last_edge;
  assign frame_done = run && last_edge && last_bit;
  assign busy       = run;
  assign state_dbg  = state;

  always_comb begin
    sample_tick             = '0;
    sample_tick[SAMPLE_MID] = run && (edge_cnt == mid_q);
`ifdef UART_RX_TRIPLE_SAMPLE_EN
    sample_tick[SAMPLE_EARLY] = run && (edge_cnt == mid_q - ONE_E);
    sample_tick[SAMPLE_LATE]  = run && (edge_cnt == mid_q + ONE_E);
`else
    sample_tick[SAMPLE_EARLY] = 1'b0;
    sample_tick[SAMPLE_LATE]  = 1'b0;
`endif
  end

endmodule
